maze_gen_dfs: RTL and testbench

- Parametrised maze generator for a WIDTH x HEIGHT cell grid, using the iterative randomised depth-first "recursive backtracker" algorithm.
- Holds an explicit cell stack, a visited map and a 32-bit Galois LFSR; carves one wall or pops the stack once per cycle.
- Outputs complete wall bitmaps to the renderer and player-movement logic.
- Generalises the fixed 15x10 generator to any grid size, adds deterministic seeding and a done pulse.

---
 rtl/maze_gen_dfs.sv | 158 +++++++++++++++
 tb/tb_maze_gen_dfs.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_gen_dfs.sv
// Randomised depth-first (recursive backtracker) maze generator for a WIDTH x HEIGHT grid.
// One carve or one stack pop per cycle; wall bitmaps are valid whenever busy is low.
module maze_gen_dfs #(
  parameter int unsigned WIDTH     = 15,
  parameter int unsigned HEIGHT    = 10,
  parameter logic [31:0] LFSR_TAPS = 32'h80200003
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [31:0]                  seed,
  output logic                         busy,
  output logic                         done,
  output logic [WIDTH*(HEIGHT+1)-1:0]  h_walls,
  output logic [(WIDTH+1)*HEIGHT-1:0]  v_walls
);

  localparam int unsigned N  = WIDTH * HEIGHT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned SD = (N > 1) ? N - 1 : 1;
  localparam int unsigned HB = WIDTH * (HEIGHT + 1);
  localparam int unsigned VB = (WIDTH + 1) * HEIGHT;
  localparam int          W  = int'(WIDTH);
  localparam int          H  = int'(HEIGHT);

  typedef enum logic [1:0] {StIdle, StInit, StStep, StDone} state_e;

  state_e          state_q, state_d;
  logic [31:0]     lfsr_q, lfsr_d, lfsr_adv;
  logic [HB-1:0]   h_q, h_d;
  logic [VB-1:0]   v_q, v_d;
  logic [N-1:0]    vis_q, vis_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   sp_q, sp_d;
  logic [CW-1:0]   stack_q [SD];
  logic            push;
  logic [CW-1:0]   cur_idx;
  logic [3:0]      nb;
  logic [1:0]      dir;
  int              ci;

  // Unvisited in-bounds neighbours and the LFSR-rotated first choice among them.
  always_comb begin
    logic [1:0] cand;
    int xi, yi;
    xi    = int'(x_q);
    yi    = int'(y_q);
    ci    = yi * W + xi;
    nb[0] = (yi > 0)     && !vis_q[(yi > 0)     ? ci - W : ci];
    nb[1] = (xi + 1 < W) && !vis_q[(xi + 1 < W) ? ci + 1 : ci];
    nb[2] = (yi + 1 < H) && !vis_q[(yi + 1 < H) ? ci + W : ci];
    nb[3] = (xi > 0)     && !vis_q[(xi > 0)     ? ci - 1 : ci];
    dir   = lfsr_q[1:0];
    cand  = lfsr_q[1:0];
    for (int k = 3; k >= 0; k--) begin
      cand = lfsr_q[1:0] + 2'(k);
      if (nb[cand]) dir = cand;
    end
    cur_idx = CW'(ci);
  end

  assign lfsr_adv = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      lfsr_q  <= 32'h1;
      h_q     <= '1;
      v_q     <= '1;
      vis_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      h_q     <= h_d;
      v_q     <= v_d;
      vis_q   <= vis_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sp_q    <= sp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q] <= cur_idx;
  end

  // DONE lasts one cycle so that done can be decoded straight from the state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: state_d = enable ? StInit : StIdle;
      StInit:         state_d = StStep;
      StStep:         if (nb == 4'b0 && sp_q == '0) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StInit) || (state_q == StStep);
    done = (state_q == StDone);
  end

  always_comb begin
    int pi;
    pi     = 0;
    lfsr_d = lfsr_q;
    h_d    = h_q;
    v_d    = v_q;
    vis_d  = vis_q;
    x_d    = x_q;
    y_d    = y_q;
    sp_d   = sp_q;
    push   = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (enable) lfsr_d = (seed == 32'h0) ? 32'h1 : seed;
      end
      StInit: begin
        h_d      = '1;
        v_d      = '1;
        vis_d    = '0;
        vis_d[0] = 1'b1;
        x_d      = '0;
        y_d      = '0;
        sp_d     = '0;
      end
      StStep: begin
        lfsr_d = lfsr_adv;
        if (nb != 4'b0) begin
          push = 1'b1;
          sp_d = sp_q + 1'b1;
          unique case (dir)
            2'd0: begin h_d[ci] = 1'b0;         y_d = y_q - 1'b1; vis_d[ci - W] = 1'b1; end
            2'd1: begin v_d[ci + ci / W + 1] = 1'b0; x_d = x_q + 1'b1; vis_d[ci + 1] = 1'b1; end
            2'd2: begin h_d[ci + W] = 1'b0;     y_d = y_q + 1'b1; vis_d[ci + W] = 1'b1; end
            default: begin v_d[ci + ci / W] = 1'b0; x_d = x_q - 1'b1; vis_d[ci - 1] = 1'b1; end
          endcase
        end else if (sp_q != '0) begin
          sp_d = sp_q - 1'b1;
          pi   = int'(stack_q[sp_q - 1'b1]);
          x_d  = XW'(pi % W);
          y_d  = YW'(pi / W);
        end
      end
      default: ;
    endcase
  end

  assign h_walls = h_q;
  assign v_walls = v_q;

endmodule

// File: tb/tb_maze_gen_dfs.sv
// Bench for maze_gen_dfs: three grid sizes checked against a queue-based reference model,
// structural maze invariants, and hand-written abort / re-enable sequences.
module tb_maze_gen_dfs;

  localparam logic [31:0] TAPS = 32'h80200003;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] seed = 32'h0;
  logic [2:0]  en = 3'b0;
  logic [2:0]  busy_v, done_v;
  logic [164:0] h0;
  logic [159:0] v0;
  logic [3:0]   h1;
  logic [2:0]   v1;
  logic [1:0]   h2, v2;

  int total = 0;
  int bad   = 0;
  logic [164:0] m_h, m_v;

  always #5 clk = ~clk;

  maze_gen_dfs #(.WIDTH(15), .HEIGHT(10)) u_big (
    .clk(clk), .rst(rst), .enable(en[0]), .seed(seed),
    .busy(busy_v[0]), .done(done_v[0]), .h_walls(h0), .v_walls(v0));
  maze_gen_dfs #(.WIDTH(2), .HEIGHT(1)) u_small (
    .clk(clk), .rst(rst), .enable(en[1]), .seed(seed),
    .busy(busy_v[1]), .done(done_v[1]), .h_walls(h1), .v_walls(v1));
  maze_gen_dfs #(.WIDTH(1), .HEIGHT(1)) u_one (
    .clk(clk), .rst(rst), .enable(en[2]), .seed(seed),
    .busy(busy_v[2]), .done(done_v[2]), .h_walls(h2), .v_walls(v2));

  function automatic int wdim(int which);
    return (which == 0) ? 15 : (which == 1) ? 2 : 1;
  endfunction

  function automatic int hdim(int which);
    return (which == 0) ? 10 : 1;
  endfunction

  function automatic logic [164:0] dut_h(int which);
    return (which == 0) ? h0 : (which == 1) ? 165'(h1) : 165'(h2);
  endfunction

  function automatic logic [164:0] dut_v(int which);
    return (which == 0) ? 165'(v0) : (which == 1) ? 165'(v1) : 165'(v2);
  endfunction

  function automatic logic [164:0] ones(int n);
    logic [164:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] lfsr_next(logic [31:0] l);
    return l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
  endfunction

  // Reference maze: explicit cell queue as a stack, plain (x,y) arithmetic.
  function automatic void ref_gen(int w, int h, logic [31:0] s);
    bit vis[];
    int stk[$];
    int cx, cy, d, r;
    bit ok[4];
    logic [31:0] l;
    vis = new[w * h];
    m_h = ones(w * (h + 1));
    m_v = ones((w + 1) * h);
    cx = 0; cy = 0;
    vis[0] = 1'b1;
    l = (s == 32'h0) ? 32'h1 : s;
    forever begin
      ok[0] = (cy > 0)     && !vis[(cy - 1) * w + cx];
      ok[1] = (cx + 1 < w) && !vis[cy * w + cx + 1];
      ok[2] = (cy + 1 < h) && !vis[(cy + 1) * w + cx];
      ok[3] = (cx > 0)     && !vis[cy * w + cx - 1];
      if (ok[0] || ok[1] || ok[2] || ok[3]) begin
        r = int'(l[1:0]);
        d = -1;
        for (int k = 0; k < 4; k++) if (d < 0 && ok[(r + k) % 4]) d = (r + k) % 4;
        stk.push_back(cy * w + cx);
        case (d)
          0: begin m_h[cy * w + cx] = 1'b0;             cy--; end
          1: begin m_v[cy * (w + 1) + cx + 1] = 1'b0;   cx++; end
          2: begin m_h[(cy + 1) * w + cx] = 1'b0;       cy++; end
          default: begin m_v[cy * (w + 1) + cx] = 1'b0; cx--; end
        endcase
        vis[cy * w + cx] = 1'b1;
      end else if (stk.size() > 0) begin
        d = stk.pop_back();
        cx = d % w;
        cy = d / w;
      end else begin
        break;
      end
      l = lfsr_next(l);
    end
  endfunction

  function automatic int reach(int w, int h, logic [164:0] hw, logic [164:0] vw);
    bit seen[];
    int q[$];
    int c, x, y, n;
    seen = new[w * h];
    seen[0] = 1'b1;
    q.push_back(0);
    n = 1;
    while (q.size() > 0) begin
      c = q.pop_front();
      x = c % w;
      y = c / w;
      for (int d = 0; d < 4; d++) begin
        int nc;
        bit open;
        nc = -1;
        open = 1'b0;
        case (d)
          0: begin open = (y > 0)     && !hw[y * w + x];               nc = c - w; end
          1: begin open = (x + 1 < w) && !vw[y * (w + 1) + x + 1];     nc = c + 1; end
          2: begin open = (y + 1 < h) && !hw[(y + 1) * w + x];         nc = c + w; end
          default: begin open = (x > 0) && !vw[y * (w + 1) + x];       nc = c - 1; end
        endcase
        if (open && !seen[nc]) begin
          seen[nc] = 1'b1;
          q.push_back(nc);
          n++;
        end
      end
    end
    return n;
  endfunction

  function automatic bit borders_ok(int w, int h, logic [164:0] hw, logic [164:0] vw);
    bit ok;
    ok = 1'b1;
    for (int x = 0; x < w; x++) ok &= hw[x] & hw[h * w + x];
    for (int y = 0; y < h; y++) ok &= vw[y * (w + 1)] & vw[y * (w + 1) + w];
    return ok;
  endfunction

  function automatic int zeros(int n, logic [164:0] b);
    int z;
    z = 0;
    for (int i = 0; i < n; i++) if (!b[i]) z++;
    return z;
  endfunction

  task automatic chk(input string nm, input logic [164:0] act, input logic [164:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // One generation on instance `which`; optional mid-run re-enable or reset at busy cycle t.
  task automatic run(input int which, input logic [31:0] s, input int repulse_at,
                     input int reset_at, output int cyc, output int dones, output bit timed_out);
    @(negedge clk);
    seed = s;
    en[which] = 1'b1;
    @(negedge clk);
    en[which] = 1'b0;
    seed = ~s;
    cyc = 0;
    dones = 0;
    timed_out = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      if (t == reset_at) begin
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 165'(busy_v[which]), 165'(0));
        chk("abort_done", 165'(done_v[which]), 165'(0));
        chk("abort_h", dut_h(which), ones(wdim(which) * (hdim(which) + 1)));
        chk("abort_v", dut_v(which), ones((wdim(which) + 1) * hdim(which)));
        rst = 1'b1;
        timed_out = 1'b0;
        break;
      end
      if (t == repulse_at) begin
        seed = 32'd7;
        en[which] = 1'b1;
      end else begin
        en[which] = 1'b0;
      end
      if (busy_v[which]) cyc++;
      if (done_v[which]) dones++;
      if (!busy_v[which]) begin
        @(negedge clk);
        if (done_v[which]) dones++;
        timed_out = 1'b0;
        break;
      end
      @(negedge clk);
    end
    en[which] = 1'b0;
  endtask

  typedef struct {
    int          which;
    logic [31:0] seed;
    int          exp_cyc;
  } vec_t;

  vec_t        tbl[$];
  int          cyc, dones, w, h;
  bit          to;
  logic [164:0] ref9_h, ref9_v, a_h, a_v;

  initial begin
    tbl.push_back('{1, 32'd5, 4});
    tbl.push_back('{2, 32'd3, 2});
    tbl.push_back('{0, 32'hDEADBEEF, 300});
    for (int i = 0; i < 3; i++) begin
      tbl.push_back('{0, $urandom, 300});
      tbl.push_back('{1, $urandom, 4});
      tbl.push_back('{2, $urandom, 2});
    end

    repeat (2) @(negedge clk);
    chk("rst_busy", 165'(busy_v), 165'(0));
    chk("rst_done", 165'(done_v), 165'(0));
    chk("rst_h", h0, ones(165));
    chk("rst_v", 165'(v0), ones(160));
    rst = 1'b1;

    foreach (tbl[i]) begin
      w = wdim(tbl[i].which);
      h = hdim(tbl[i].which);
      run(tbl[i].which, tbl[i].seed, -1, -1, cyc, dones, to);
      chk("timeout", 165'(to), 165'(0));
      chk("busy_cycles", 165'(cyc), 165'(tbl[i].exp_cyc));
      chk("done_pulses", 165'(dones), 165'(1));
      ref_gen(w, h, tbl[i].seed);
      chk("h_model", dut_h(tbl[i].which), m_h);
      chk("v_model", dut_v(tbl[i].which), m_v);
      chk("cleared", 165'(zeros(w * (h + 1), dut_h(tbl[i].which)) +
                          zeros((w + 1) * h, dut_v(tbl[i].which))), 165'(w * h - 1));
      chk("borders", 165'(borders_ok(w, h, dut_h(tbl[i].which), dut_v(tbl[i].which))), 165'(1));
      chk("reach", 165'(reach(w, h, dut_h(tbl[i].which), dut_v(tbl[i].which))), 165'(w * h));
      if (tbl[i].which == 1) begin
        chk("small_v", 165'(v1), 165'(3'b101));
        chk("small_h", 165'(h1), 165'(4'b1111));
      end
      if (tbl[i].which == 2) begin
        chk("one_h", 165'(h2), 165'(2'b11));
        chk("one_v", 165'(v2), 165'(2'b11));
      end
    end

    // Zero seed is substituted by 1.
    run(0, 32'd0, -1, -1, cyc, dones, to);
    a_h = h0;
    a_v = 165'(v0);
    run(0, 32'd1, -1, -1, cyc, dones, to);
    chk("seed0_h", a_h, h0);
    chk("seed0_v", a_v, 165'(v0));

    run(0, 32'd9, -1, -1, cyc, dones, to);
    ref9_h = h0;
    ref9_v = 165'(v0);
    ref_gen(15, 10, 32'd9);
    chk("seed9_h_model", ref9_h, m_h);

    // Re-enable while busy must be ignored.
    run(0, 32'd9, 40, -1, cyc, dones, to);
    chk("repulse_cycles", 165'(cyc), 165'(300));
    chk("repulse_dones", 165'(dones), 165'(1));
    chk("repulse_h", h0, ref9_h);
    chk("repulse_v", 165'(v0), ref9_v);

    // Reset mid-run aborts; a later run is unaffected.
    run(0, 32'd9, -1, 50, cyc, dones, to);
    chk("abort_cycles", 165'(cyc), 165'(50));
    chk("abort_nodone", 165'(dones), 165'(0));
    run(0, 32'd9, -1, -1, cyc, dones, to);
    chk("after_abort_cycles", 165'(cyc), 165'(300));
    chk("after_abort_h", h0, ref9_h);
    chk("after_abort_v", 165'(v0), ref9_v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
